// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - signed/unsigned divide sequencer around an unsigned iterative core, owning HI/LO
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_dividend,
   input  logic [WIDTH-1:0] req_divisor,
   output logic             req_ready,
   input  logic             flush,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             mf_req,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done,
   output logic             core_start,
   output logic [WIDTH-1:0] core_dividend,
   output logic [WIDTH-1:0] core_divisor,
   input  logic [WIDTH-1:0] core_q,
   input  logic [WIDTH-1:0] core_r,
   input  logic             core_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FIX,
      S_DRAIN
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic [WIDTH-1:0] orig_dividend;
   logic             accept;
   logic             fix_write;

   // Two's-complement magnitude; the most negative value maps to itself as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

   assign req_ready  = (state == S_IDLE);
   assign accept     = (state == S_IDLE) && req_valid && !flush;
   assign fix_write  = (state == S_FIX) && !flush;
   assign core_start = (state == S_ISSUE);
   assign stall      = (state != S_IDLE) && (req_valid || mt_hi || mt_lo || mf_req);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = (req_divisor == '0) ? S_FIX : S_ISSUE;
            end
         end
         S_ISSUE: next_state = flush ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (flush) begin
               next_state = S_DRAIN;
            end else if (!core_busy) begin
               next_state = S_FIX;
            end
         end
         S_FIX:   next_state = S_IDLE;
         // The core cannot be aborted, so a flushed divide waits for it to go idle.
         S_DRAIN: begin
            if (!core_busy) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         dz            <= 1'b0;
         orig_dividend <= '0;
         core_dividend <= '0;
         core_divisor  <= '0;
      end else if (accept) begin
         neg_q         <= req_signed && (req_dividend[WIDTH-1] ^ req_divisor[WIDTH-1]);
         neg_r         <= req_signed && req_dividend[WIDTH-1];
         dz            <= (req_divisor == '0);
         orig_dividend <= req_dividend;
         core_dividend <= req_signed ? mag(req_dividend) : req_dividend;
         core_divisor  <= req_signed ? mag(req_divisor) : req_divisor;
      end
   end

   // MT writes only land in IDLE; the result write happens in FIX, so they never collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= fix_write;
         if (fix_write) begin
            if (dz) begin
               lo <= '1;
               hi <= orig_dividend;
            end else begin
               lo <= neg_q ? (~core_q + 1'b1) : core_q;
               hi <= neg_r ? (~core_r + 1'b1) : core_r;
            end
         end else if (state == S_IDLE) begin
            if (mt_hi) begin
               hi <= mt_data;
            end
            if (mt_lo) begin
               lo <= mt_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer with a behavioural divider core
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_signed;
   logic [31:0] req_dividend;
   logic [31:0] req_divisor;
   logic        req_ready;
   logic        flush;
   logic        mt_hi;
   logic        mt_lo;
   logic [31:0] mt_data;
   logic        mf_req;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        core_start;
   logic [31:0] core_dividend;
   logic [31:0] core_divisor;
   logic [31:0] core_q;
   logic [31:0] core_r;
   logic        core_busy;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   div_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_signed(req_signed),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_ready(req_ready),
      .flush(flush), .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .mf_req(mf_req),
      .stall(stall), .hi(hi), .lo(lo), .done(done),
      .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
      .core_q(core_q), .core_r(core_r), .core_busy(core_busy)
   );

   // Divider core: busy for 32 cycles including the start cycle, result fixed at start.
   int core_cnt;
   assign core_busy = core_start || (core_cnt != 0);
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         core_cnt <= 0;
         core_q   <= 32'h0;
         core_r   <= 32'h0;
      end else if (core_start) begin
         core_cnt <= 31;
         core_q   <= (core_divisor != 0) ? core_dividend / core_divisor : 32'h0;
         core_r   <= (core_divisor != 0) ? core_dividend % core_divisor : 32'h0;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
      end
   end

   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      int sa;
      int sb;
      if (b == 32'h0) begin
         q = 32'hFFFFFFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'h0;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] eq;
      logic [31:0] er;
      int          starts;
      int          lat;
      bit          got;
      ref_div(s, a, b, eq, er);
      req_signed   = s;
      req_dividend = a;
      req_divisor  = b;
      req_valid    = 1'b1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_at_req: got %b exp 1", name, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      starts = 0;
      lat    = 0;
      got    = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         if (core_start) starts++;
         if (done) begin
            got = 1'b1;
            lat = k - 1;
            break;
         end
      end
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL %s timeout: no done within 60 cycles", name);
      end else begin
         if (lat != ((b == 0) ? 1 : 34)) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d exp %0d", name, lat, (b == 0) ? 1 : 34);
         end
         tests_run++;
         if (starts != ((b == 0) ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL %s core_start_cycles: got %0d exp %0d", name, starts, (b == 0) ? 0 : 1);
         end
         tests_run++;
         if (lo !== eq) begin
            tests_failed++;
            $display("FAIL %s lo: got %h exp %h", name, lo, eq);
         end
         tests_run++;
         if (hi !== er) begin
            tests_failed++;
            $display("FAIL %s hi: got %h exp %h", name, hi, er);
         end
         tests_run++;
         if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_in_done: got %b exp 1", name, req_ready);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({hi, lo} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset hilo: got %h/%h exp 0/0", hi, lo);
      end
      tests_run++;
      if ({done, core_start, req_ready, stall} !== 4'b0010) begin
         tests_failed++;
         $display("FAIL reset ctrl: got %b exp 0010", {done, core_start, req_ready, stall});
      end
      tests_run++;
      if ({core_dividend, core_divisor} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset core_ops: got %h/%h exp 0/0", core_dividend, core_divisor);
      end
   endtask

   task automatic test_directed;
      run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, "div_7_m2");
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
      run_div(1'b0, 32'h12345678, 32'h0, "divu_by_zero");
      run_div(1'b1, 32'hFFFFFF00, 32'h0, "div_by_zero");
      run_div(1'b0, 32'h80000000, 32'h80000000, "divu_msb");
   endtask

   task automatic test_back_to_back;
      run_div(1'b0, 32'd5, 32'h0, "b2b_dz");
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, "b2b_signed");
      run_div(1'b0, 32'hDEADBEEF, 32'd3, "b2b_unsigned");
   endtask

   task automatic test_random;
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         s = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1:       b = 32'hFFFFFFFF;
            2, 3:    b = $urandom_range(1, 200);
            4:       b = -$urandom_range(1, 200);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h80000000;
         run_div(s, a, b, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_flush;
      logic [31:0] lo_before;
      bit          seen_done;
      bit          bad_ready;
      bit          back_idle;
      mt_hi   = 1'b1;
      mt_data = 32'h0000AAAA;
      @(negedge clk);
      mt_hi = 1'b0;
      tests_run++;
      if (hi !== 32'h0000AAAA) begin
         tests_failed++;
         $display("FAIL flush mthi: got %h exp 0000aaaa", hi);
      end
      lo_before    = lo;
      req_signed   = 1'b0;
      req_dividend = 32'd9;
      req_divisor  = 32'd4;
      req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      seen_done = 1'b0;
      bad_ready = 1'b0;
      back_idle = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         flush = (k == 10);
         if (done) seen_done = 1'b1;
         if (core_busy && req_ready) bad_ready = 1'b1;
         if (k > 10 && req_ready) begin
            back_idle = 1'b1;
            break;
         end
         @(negedge clk);
      end
      flush = 1'b0;
      tests_run++;
      if (!back_idle) begin
         tests_failed++;
         $display("FAIL flush drain_timeout: req_ready never returned");
      end
      tests_run++;
      if (seen_done || bad_ready) begin
         tests_failed++;
         $display("FAIL flush protocol: done_seen %b ready_while_busy %b exp 0 0", seen_done, bad_ready);
      end
      tests_run++;
      if (hi !== 32'h0000AAAA || lo !== lo_before) begin
         tests_failed++;
         $display("FAIL flush hilo: got %h/%h exp 0000aaaa/%h", hi, lo, lo_before);
      end
      run_div(1'b0, 32'd9, 32'd4, "after_flush");
   endtask

   task automatic test_interlock;
      logic [31:0] eq;
      logic [31:0] er;
      bit          bad_stall;
      bit          bad_lo;
      bit          got;
      ref_div(1'b0, 32'd1000, 32'd3, eq, er);
      req_signed   = 1'b0;
      req_dividend = 32'd1000;
      req_divisor  = 32'd3;
      req_valid    = 1'b1;
      mt_lo        = 1'b1;
      mf_req       = 1'b1;
      mt_data      = 32'h00005555;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      mt_data   = 32'h00007777;
      bad_stall = 1'b0;
      bad_lo    = 1'b0;
      got       = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (stall !== 1'b1) bad_stall = 1'b1;
         if (lo !== 32'h00005555) bad_lo = 1'b1;
      end
      mt_lo = 1'b0;
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL interlock timeout: no done within 60 cycles");
      end
      tests_run++;
      if (bad_stall || bad_lo) begin
         tests_failed++;
         $display("FAIL interlock during_divide: stall_dropped %b mtlo_applied %b exp 0 0", bad_stall, bad_lo);
      end
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL interlock done_stall: got %b exp 0", stall);
      end
      tests_run++;
      if (lo !== eq || hi !== er) begin
         tests_failed++;
         $display("FAIL interlock result: got %h/%h exp %h/%h", lo, hi, eq, er);
      end
      mf_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (lo !== eq) begin
         tests_failed++;
         $display("FAIL interlock lo_after: got %h exp %h", lo, eq);
      end
   endtask

   task automatic test_async_reset;
      bit seen_done;
      req_signed   = 1'b0;
      req_dividend = 32'd1000;
      req_divisor  = 32'd7;
      req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0 || core_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset mid_op: ready %b busy %b exp 0 1", req_ready, core_busy);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if ({hi, lo} !== 64'h0 || {core_dividend, core_divisor} !== 64'h0) begin
         tests_failed++;
         $display("FAIL areset regs: got %h/%h ops %h/%h exp zeros", hi, lo, core_dividend, core_divisor);
      end
      tests_run++;
      if ({done, core_start, req_ready, stall} !== 4'b0010) begin
         tests_failed++;
         $display("FAIL areset ctrl: got %b exp 0010", {done, core_start, req_ready, stall});
      end
      @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      tests_run++;
      if (seen_done) begin
         tests_failed++;
         $display("FAIL areset spurious_done: got 1 exp 0");
      end
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, "after_reset");
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_signed   = 1'b0;
      req_dividend = 32'h0;
      req_divisor  = 32'h0;
      flush        = 1'b0;
      mt_hi        = 1'b0;
      mt_lo        = 1'b0;
      mt_data      = 32'h0;
      mf_req       = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_interlock();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide controller for the CPU's HI/LO unit. It accepts DIV/DIVU requests from the execute stage and applies signed pre- and post-processing around the external unsigned iterative divider core. It sequences that core, handles divide-by-zero and pipeline flush, and owns the HI/LO registers, including MTHI/MTLO/MFHI/MFLO interlock.

## Interface
- WIDTH, 32, operand/result width. Core contract and tests are defined for 32.
- clk  in  1  rising-edge clock for all controller state.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  divide request, accepted when req_valid && req_ready && !flush.
- req_signed  in  1  1 = DIV (signed), 0 = DIVU.
- req_dividend  in  WIDTH  rs operand.
- req_divisor  in  WIDTH  rt operand.
- req_ready  out  1  high only in IDLE.
- flush  in  1  pipeline flush; aborts the in-flight divide.
- mt_hi, mt_lo  in  1  MTHI/MTLO write strobes.
- mt_data  in  WIDTH  MTHI/MTLO data.
- mf_req  in  1  MFHI/MFLO reading this cycle.
- stall  out  1  combinational: (state != IDLE) && (req_valid || mt_hi || mt_lo || mf_req).
- hi, lo  out  WIDTH  architectural HI (remainder) and LO (quotient).
- done  out  1  one-cycle pulse, coincident with the HI/LO result update.
- core_start  out  1  one-cycle start pulse to the divider core.
- core_dividend, core_divisor  out  WIDTH  unsigned operands, held stable from ISSUE through WAIT.
- core_q, core_r  in  WIDTH  core quotient and (corrected) remainder.
- core_busy  in  1  core busy. Rises within the core_start cycle; stays high for exactly 32 cycles.

## Operation
- States: IDLE, ISSUE, WAIT, FIX, DRAIN.
- **IDLE, accept:**
  - Latch neg_q = req_signed && (dividend[W-1] ^ divisor[W-1]).
  - Latch neg_r = req_signed && dividend[W-1].
  - Latch the original dividend.
  - core_dividend = req_signed ? |dividend| : dividend; same rule for core_divisor. |x| is two's-complement negate if MSB is set, so |0x80000000| = 0x80000000 unsigned.
  - If divisor == 0: go to FIX with dz flag set (core not started). Otherwise go to ISSUE.
- **ISSUE:** core_start = 1 for exactly this cycle, then go to WAIT.
- **WAIT:** stay while core_busy = 1. On the first rising edge with core_busy = 0, go to FIX.
- **FIX:**
  - If dz: lo <= all ones, hi <= latched dividend.
  - Otherwise: lo <= neg_q ? -core_q : core_q, and hi <= neg_r ? -core_r : core_r.
  - Assert done, go to IDLE.
  - Arithmetic is modulo 2^WIDTH. 0x80000000 / -1 (signed) gives lo = 0x80000000, hi = 0, with no trap.
- **flush:**
  - In ISSUE or WAIT: go to DRAIN. In FIX: go to IDLE. In all cases no HI/LO write and no done.
  - In IDLE or DRAIN: flush has no effect.
  - flush with req_valid in the same cycle: flush wins; the request is not accepted.
- **DRAIN:** wait for core_busy = 0 at a rising edge, then go to IDLE. The core cannot be aborted, so a new request is never issued while the core is still running.
- **mt_hi/mt_lo:**
  - Written in IDLE only; while stalled they have no effect.
  - Simultaneous mt_* and request acceptance in IDLE: the MT write happens now; the divide result overwrites later.
  - FIX write and done take priority, and are always in a non-IDLE state, so no collision.
- **mf_req:** hi/lo are always driven. Consumers treat them as valid only when stall = 0.

## Timing
- **Reset:**
  - state IDLE; hi = lo = 0; done = 0; core_start = 0; core_dividend = core_divisor = 0; all flags 0.
  - req_ready = 1. stall = 0.
  - Reset mid-operation returns to IDLE immediately, without draining. The core is reset from the same reset net.
- **Normal divide, accept at edge P0:**
  - ISSUE during P0–P1.
  - WAIT observes core_busy = 1 at P1..P32 and core_busy = 0 at P33.
  - FIX during P33–P34. hi/lo update and done = 1 from edge P34. Latency is 34 cycles.
- **Divide-by-zero:** accept at P0, FIX during P0–P1, result and done at P1. Latency is 1 cycle.
- **Back-to-back:** req_ready is high in the done cycle, so the next request can be accepted at the edge ending the done cycle.
- **Interlock:** an mf_req held during a divide stalls until the done cycle, then reads the new value in that cycle.

## Test plan
- DIVU 100 / 7 -> lo = 14, hi = 2, done exactly 34 cycles after accept, core_start high for exactly 1 cycle.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 0x12345678 / 0 -> no core_start, done 1 cycle after accept, lo = 0xFFFFFFFF, hi = 0x12345678.
- MTHI 0xAAAA, then DIVU 9 / 4 with flush at cycle 10:
  - No done; hi stays 0xAAAA, lo unchanged.
  - req_ready stays low until core_busy falls.
  - Next DIVU 9 / 4 -> lo = 2, hi = 1.
- mf_req and mt_lo held during a divide -> stall = 1 every cycle until the done cycle. mt_lo is not applied while stalled.
- Async reset asserted mid-WAIT -> all outputs return to reset values within the same cycle, with no done. A subsequent divide completes correctly.
